lm32_wb_arbiter: RTL and testbench

Two-master to one-slave Wishbone arbiter that sits directly downstream of the LM32 CPU top level. It merges the instruction bus (master 0) and data bus (master 1) onto a single shared slave bus, typically the SoC memory/peripheral interconnect. Grants are round-robin, held for whole cycles, bursts and locked sequences. A per-access watchdog terminates stalled slave accesses with an error.

---
 rtl/lm32_wb_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_lm32_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm32_wb_arbiter.sv
// lm32_wb_arbiter: two-master (I-bus = m0, D-bus = m1) to one-slave Wishbone
// arbiter. Round-robin grant that is held for whole cycles and locked
// sequences, with a per-access watchdog that terminates stalled accesses.
module lm32_wb_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [2:0]  m0_cti_i,
   input  logic [1:0]  m0_bte_i,
   input  logic        m0_we_i,
   input  logic        m0_lock_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic [31:0] m0_dat_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic        m0_rty_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [2:0]  m1_cti_i,
   input  logic [1:0]  m1_bte_i,
   input  logic        m1_we_i,
   input  logic        m1_lock_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic [31:0] m1_dat_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic        m1_rty_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic [2:0]  s_cti_o,
   output logic [1:0]  s_bte_o,
   output logic        s_we_o,
   output logic        s_lock_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   input  logic        s_err_i,
   input  logic        s_rty_i,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_TMO = CNT_W'(TIMEOUT);

   state_t             r_state;
   state_t             w_next;
   logic               r_last;      // 1: master 1 was granted most recently
   logic [CNT_W-1:0]   r_cnt;

   logic [31:0]        w_adr;
   logic [31:0]        w_wdat;
   logic [3:0]         w_sel;
   logic [2:0]         w_cti;
   logic [1:0]         w_bte;
   logic               w_we;
   logic               w_lock;
   logic               w_cyc;
   logic               w_stb;
   logic               w_g0;
   logic               w_g1;
   logic               w_resp;
   logic               w_fire;

   assign w_g0   = (r_state == ST_GNT0);
   assign w_g1   = (r_state == ST_GNT1);
   assign w_resp = s_ack_i | s_err_i | s_rty_i;

   // Watchdog fires on a waiting strobe at the limit; a real response wins.
   assign w_fire = (TIMEOUT != 0) && (w_g0 || w_g1) && w_stb
                   && (r_cnt == LP_TMO) && !w_resp;

   // Next-state arbitration: round-robin on ties, grant held by cyc or lock.
   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               w_next = r_last ? ST_GNT0 : ST_GNT1;
            end else if (m0_cyc_i) begin
               w_next = ST_GNT0;
            end else if (m1_cyc_i) begin
               w_next = ST_GNT1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_GNT0: begin
            if (m0_cyc_i || m0_lock_i) begin
               w_next = ST_GNT0;
            end else if (m1_cyc_i) begin
               w_next = ST_GNT1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_GNT1: begin
            if (m1_cyc_i || m1_lock_i) begin
               w_next = ST_GNT1;
            end else if (m0_cyc_i) begin
               w_next = ST_GNT0;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Request mux: the owner's request reaches the slave, nothing when idle.
   always_comb begin
      w_adr  = 32'h0;
      w_wdat = 32'h0;
      w_sel  = 4'h0;
      w_cti  = 3'h0;
      w_bte  = 2'h0;
      w_we   = 1'b0;
      w_lock = 1'b0;
      w_cyc  = 1'b0;
      w_stb  = 1'b0;
      case (r_state)
         ST_GNT0: begin
            w_adr  = m0_adr_i;
            w_wdat = m0_dat_i;
            w_sel  = m0_sel_i;
            w_cti  = m0_cti_i;
            w_bte  = m0_bte_i;
            w_we   = m0_we_i;
            w_lock = m0_lock_i;
            w_cyc  = m0_cyc_i;
            w_stb  = m0_stb_i;
         end
         ST_GNT1: begin
            w_adr  = m1_adr_i;
            w_wdat = m1_dat_i;
            w_sel  = m1_sel_i;
            w_cti  = m1_cti_i;
            w_bte  = m1_bte_i;
            w_we   = m1_we_i;
            w_lock = m1_lock_i;
            w_cyc  = m1_cyc_i;
            w_stb  = m1_stb_i;
         end
         default: begin
            w_adr  = 32'h0;
         end
      endcase
   end

   assign s_adr_o  = w_adr;
   assign s_dat_o  = w_wdat;
   assign s_sel_o  = w_sel;
   assign s_cti_o  = w_cti;
   assign s_bte_o  = w_bte;
   assign s_we_o   = w_we;
   assign s_lock_o = w_lock;
   assign s_cyc_o  = w_cyc & ~w_fire;
   assign s_stb_o  = w_stb & ~w_fire;

   // Responses only ever reach the granted master; watchdog adds an error.
   assign m0_dat_o  = w_g0 ? s_dat_i : 32'h0;
   assign m0_ack_o  = w_g0 & s_ack_i;
   assign m0_err_o  = w_g0 & (s_err_i | w_fire);
   assign m0_rty_o  = w_g0 & s_rty_i;
   assign m1_dat_o  = w_g1 ? s_dat_i : 32'h0;
   assign m1_ack_o  = w_g1 & s_ack_i;
   assign m1_err_o  = w_g1 & (s_err_i | w_fire);
   assign m1_rty_o  = w_g1 & s_rty_i;
   assign timeout_o = w_fire;

   // State, last-grant memory and watchdog counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == ST_GNT0) begin
            r_last <= 1'b0;
         end else if (w_next == ST_GNT1) begin
            r_last <= 1'b1;
         end
         if ((w_next != r_state) || w_resp || !s_stb_o) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_lm32_wb_arbiter.sv
// Bench for lm32_wb_arbiter: two instances (watchdog 4 and disabled) share
// stimulus; a grant/age model derived from the arbitration rules predicts
// every output each cycle. Directed scenarios plus a randomized soak.
module tb_lm32_wb_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] m_adr[2];
   logic [31:0] m_dat[2];
   logic [3:0]  m_sel[2];
   logic [2:0]  m_cti[2];
   logic [1:0]  m_bte[2];
   logic        m_we[2];
   logic        m_lock[2];
   logic        m_cyc[2];
   logic        m_stb[2];
   logic [31:0] s_dat;
   logic        s_ack, s_err, s_rty;

   logic [76:0] req_bus[2];
   logic [34:0] rsp0[2];
   logic [34:0] rsp1[2];
   logic        tmo_o[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] sa, sd, d0, d1;
      logic [3:0]  ss;
      logic [2:0]  sc;
      logic [1:0]  sb;
      logic        swe, slk, scy, sst, a0, e0, r0, a1, e1, r1, to;
      lm32_wb_arbiter #(.TIMEOUT((g == 0) ? 4 : 0), .CNT_W(8)) u_dut (
         .clk_i(clk), .rst_i(rst),
         .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
         .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]), .m0_we_i(m_we[0]),
         .m0_lock_i(m_lock[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
         .m0_dat_o(d0), .m0_ack_o(a0), .m0_err_o(e0), .m0_rty_o(r0),
         .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
         .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]), .m1_we_i(m_we[1]),
         .m1_lock_i(m_lock[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
         .m1_dat_o(d1), .m1_ack_o(a1), .m1_err_o(e1), .m1_rty_o(r1),
         .s_adr_o(sa), .s_dat_o(sd), .s_sel_o(ss), .s_cti_o(sc), .s_bte_o(sb),
         .s_we_o(swe), .s_lock_o(slk), .s_cyc_o(scy), .s_stb_o(sst),
         .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
         .timeout_o(to)
      );
      assign req_bus[g] = {sa, sd, ss, sc, sb, swe, slk, scy, sst};
      assign rsp0[g]    = {d0, a0, e0, r0};
      assign rsp1[g]    = {d1, a1, e1, r1};
      assign tmo_o[g]   = to;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Model: owner (-1 none), last granted master, cycles the strobe has waited.
   int own[2];
   int lst[2];
   int age[2];
   int tmo[2] = '{4, 0};

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         own[k] = -1;
         lst[k] = 0;
         age[k] = 0;
      end
   endtask

   // Compare all outputs of both instances, then advance the model one edge.
   task automatic model_cycle(input bit do_update);
      for (int k = 0; k < 2; k++) begin
         int o;
         int n;
         bit fire;
         bit resp;
         bit ostb;
         logic [76:0] er;
         logic [34:0] ex[2];
         o    = own[k];
         resp = s_ack | s_err | s_rty;
         ostb = (o >= 0) ? m_stb[o] : 1'b0;
         fire = (o >= 0) && (tmo[k] != 0) && (age[k] == tmo[k]) && ostb && !resp;
         er = '0;
         if (o >= 0)
            er = {m_adr[o], m_dat[o], m_sel[o], m_cti[o], m_bte[o], m_we[o],
                  m_lock[o], m_cyc[o] & ~fire, m_stb[o] & ~fire};
         for (int x = 0; x < 2; x++)
            ex[x] = (o == x) ? {s_dat, s_ack, s_err | fire, s_rty} : 35'h0;
         chk($sformatf("req_i%0d", k), 128'(req_bus[k]), 128'(er));
         chk($sformatf("rsp0_i%0d", k), 128'(rsp0[k]), 128'(ex[0]));
         chk($sformatf("rsp1_i%0d", k), 128'(rsp1[k]), 128'(ex[1]));
         chk($sformatf("tmo_i%0d", k), 128'(tmo_o[k]), 128'(fire));
         if (do_update) begin
            if (o < 0) begin
               if (m_cyc[0] && m_cyc[1]) n = 1 - lst[k];
               else if (m_cyc[0])        n = 0;
               else if (m_cyc[1])        n = 1;
               else                      n = -1;
            end else begin
               if (m_cyc[o] || m_lock[o]) n = o;
               else if (m_cyc[1 - o])     n = 1 - o;
               else                       n = -1;
            end
            if (n != o || o < 0 || resp || !ostb || fire) age[k] = 0;
            else age[k] = age[k] + 1;
            if (n >= 0 && n != o) lst[k] = n;
            own[k] = n;
         end
      end
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic advance();
      if (rst) model_reset();
      model_cycle(!rst);
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   task automatic idle_inputs();
      for (int m = 0; m < 2; m++) begin
         m_adr[m] = 32'h0; m_dat[m] = 32'h0; m_sel[m] = 4'h0; m_cti[m] = 3'h0;
         m_bte[m] = 2'h0;  m_we[m] = 1'b0;  m_lock[m] = 1'b0; m_cyc[m] = 1'b0;
         m_stb[m] = 1'b0;
      end
      s_dat = 32'h0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      idle_inputs();
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;
   endtask

   task automatic req(input int m, input logic [31:0] a, input logic [2:0] cti);
      m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_adr[m] = a; m_cti[m] = cti;
      m_sel[m] = 4'hF; m_bte[m] = 2'b00;
   endtask

   bit quiet;

   initial begin
      idle_inputs();
      model_reset();
      do_reset();

      // Single master read, ack at cycle 3.
      req(1, 32'h0000_1000, 3'b000);
      step(); step(); step();
      s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
      settle();
      chk("sm_ack", 128'(rsp1[0][2]), 128'(1'b1));
      chk("sm_dat", 128'(rsp1[0][34:3]), 128'(32'hDEAD_BEEF));
      chk("sm_m0ack", 128'(rsp0[0][2]), 128'(1'b0));
      advance();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
      step();

      // Tie after reset goes to m1, then m0, then m1 again.
      do_reset();
      req(0, 32'h0000_0A00, 3'b000);
      req(1, 32'h0000_0B00, 3'b000);
      step();
      s_ack = 1'b1;
      settle();
      chk("tie_first", 128'(req_bus[0][76:45]), 128'(32'h0000_0B00));
      advance();
      m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0;
      step();
      settle();
      chk("tie_second", 128'(req_bus[0][76:45]), 128'(32'h0000_0A00));
      advance();
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      step();
      req(0, 32'h0000_0A04, 3'b000);
      req(1, 32'h0000_0B04, 3'b000);
      step();
      settle();
      chk("tie_third", 128'(req_bus[0][76:45]), 128'(32'h0000_0B04));
      advance();
      idle_inputs();
      step();

      // Burst by m0 while m1 waits; then handoff to m1 with no idle cycle.
      do_reset();
      req(0, 32'h0000_2000, 3'b010);
      step();
      req(1, 32'h0000_3000, 3'b000);
      for (int b = 0; b < 4; b++) begin
         m_adr[0] = 32'h0000_2000 + 32'(b * 4);
         m_cti[0] = (b == 3) ? 3'b111 : 3'b010;
         s_ack = 1'b1;
         settle();
         chk("burst_ack0", 128'(rsp0[0][2]), 128'(1'b1));
         chk("burst_ack1", 128'(rsp1[0][2]), 128'(1'b0));
         advance();
      end
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
      step();
      settle();
      chk("handoff_cyc", 128'(req_bus[0][1]), 128'(1'b1));
      chk("handoff_adr", 128'(req_bus[0][76:45]), 128'(32'h0000_3000));
      advance();
      idle_inputs();
      step();

      // Lock keeps the grant across a cyc gap.
      do_reset();
      req(0, 32'h0000_4000, 3'b000);
      m_lock[0] = 1'b1;
      step();
      req(1, 32'h0000_5000, 3'b000);
      m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      step();
      settle();
      chk("lock_hold", 128'(req_bus[0][76:45]), 128'(32'h0000_4000));
      advance();
      idle_inputs();
      step(); step();

      // Watchdog: stb first on slave bus at cycle 1, err at cycle 5.
      do_reset();
      req(0, 32'h0000_6000, 3'b000);
      for (int c = 0; c < 5; c++) step();
      settle();
      chk("wd_err", 128'(rsp0[0][1]), 128'(1'b1));
      chk("wd_to", 128'(tmo_o[0]), 128'(1'b1));
      chk("wd_stb", 128'(req_bus[0][0]), 128'(1'b0));
      chk("wd_off_err", 128'(rsp0[1][1]), 128'(1'b0));
      chk("wd_off_stb", 128'(req_bus[1][0]), 128'(1'b1));
      advance();
      for (int c = 0; c < 6; c++) step();

      // Async reset mid-access zeroes outputs before any clock edge.
      s_ack = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      model_cycle(1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_inputs();
      step();

      // Randomized soak with one asynchronous reset in the middle.
      quiet = 1'b0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(7) == 0) m_cyc[m] = ~m_cyc[m];
            if ($urandom_range(15) == 0) m_lock[m] = ~m_lock[m];
            m_stb[m] = m_cyc[m] & ($urandom_range(3) != 0);
            m_adr[m] = $urandom;
            m_dat[m] = $urandom;
            m_sel[m] = 4'($urandom);
            m_cti[m] = 3'($urandom);
            m_bte[m] = 2'($urandom);
            m_we[m]  = 1'($urandom);
         end
         if (cyc % 64 == 0) quiet = ($urandom_range(1) == 0);
         s_dat = $urandom;
         s_ack = !quiet && ($urandom_range(2) == 0);
         s_err = !quiet && ($urandom_range(15) == 0);
         s_rty = !quiet && ($urandom_range(15) == 0);
         if (cyc == 700) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            model_cycle(1'b0);
            @(posedge clk);
            #1;
            rst = 1'b0;
         end else begin
            step();
         end
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
